key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 86 ++++++++
 tb/tb_key_debounce.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces a push-button into a clean level plus press/release pulses
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release
);
  localparam int TW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TERM = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic REL = KEY_ACTIVE_LOW;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic sync0, sync1, key_lvl, term;
  logic state_lvl_n, press_n, release_n;
  assign key_lvl = sync1 ^ REL;
  assign term = timer == TERM;
  // two-flop synchronizer; reset loads the released pin level so no false press appears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync0, sync1} <= {REL, REL};
    else {sync0, sync1} <= {key_in, sync0};
  // state, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      key_state   <= state_lvl_n;
      key_press   <= press_n;
      key_release <= release_n;
    end
  // next state: a WAIT state survives only while the level holds; the timer restarts on every state change
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    state_lvl_n = key_state;
    press_n     = 1'b0;
    release_n   = 1'b0;
    case (state)
      IDLE:
        if (key_lvl) begin
          state_n = PRESS_WAIT;
          timer_n = '0;
        end
      PRESS_WAIT:
        if (!key_lvl) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (term) begin
          state_n     = PRESSED;
          timer_n     = '0;
          state_lvl_n = 1'b1;
          press_n     = 1'b1;
        end else timer_n = timer + 1'b1;
      PRESSED:
        if (!key_lvl) begin
          state_n = RELEASE_WAIT;
          timer_n = '0;
        end
      RELEASE_WAIT:
        if (key_lvl) begin
          state_n = PRESSED;
          timer_n = '0;
        end else if (term) begin
          state_n     = IDLE;
          timer_n     = '0;
          state_lvl_n = 1'b0;
          release_n   = 1'b1;
        end else timer_n = timer + 1'b1;
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table vectors, corner sequences and random bounce against a run-length reference model
module tb_key_debounce;
  localparam int D = 4;
  typedef struct {
    logic       key;
    logic [2:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_state, key_press, key_release;
  int vectors = 0;
  int miscompares = 0;
  vec_t tv[40];
  logic m_s0, m_s1, acc, e_press, e_rel;
  int run;
  logic [2:0] cnt;
  int wraps;
  key_debounce #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release)
  );
  always #5 clk = ~clk;
  // reference: pin seen two edges late; a new level is accepted once it has differed on D+1 consecutive edges
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_s0 <= 1'b1;
      m_s1 <= 1'b1;
      acc <= 1'b0;
      run <= 0;
      e_press <= 1'b0;
      e_rel <= 1'b0;
    end else begin
      m_s0 <= key_in;
      m_s1 <= m_s0;
      e_press <= 1'b0;
      e_rel <= 1'b0;
      if (~m_s1 != acc) begin
        if (run == D) begin
          acc <= ~m_s1;
          run <= 0;
          e_press <= ~m_s1;
          e_rel <= m_s1;
        end else run <= run + 1;
      end else run <= 0;
    end
  // downstream modulo-8 counter driven by key_press
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      wraps <= 0;
    end else if (key_press) begin
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) wraps <= wraps + 1;
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [2:0] outs();
    return {key_state, key_press, key_release};
  endfunction
  task automatic step(input logic k);
    key_in = k;
    @(negedge clk);
  endtask
  task automatic hold(input logic k, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      step(k);
      chk(nm, outs(), {acc, e_press, e_rel});
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      tv[i].key = i >= 8;
      tv[i].exp = i < 6 ? 3'b000 : i == 6 ? 3'b110 : i < 14 ? 3'b100 : i == 14 ? 3'b001 : 3'b000;
    end
    for (int j = 0; j < 24; j++) begin
      tv[16 + j].key = j < 20 ? (j % 4 == 3) : 1'b1;
      tv[16 + j].exp = 3'b000;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 3'b000);
    rst_n = 1'b1;
    repeat (3) step(1'b1);
    chk("idle_after_reset", outs(), 3'b000);
    for (int i = 0; i < 40; i++) begin
      step(tv[i].key);
      chk($sformatf("table[%0d]", i), outs(), tv[i].exp);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      chk("terminal_bounce", outs(), 3'b000);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      chk("terminal_bounce_after", outs(), 3'b000);
    end
    hold(1'b0, 5, "short_low_model");
    hold(1'b1, 12, "short_low_release_model");
    hold(1'b0, 10, "press_before_reset");
    chk("pressed_level", key_state, 1'b1);
    repeat (5) step(1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_release_wait", outs(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      chk("no_pulse_after_reset", outs(), 3'b000);
    end
    repeat (5) step(1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_press_wait", outs(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      chk("held_through_reset", outs(), i < 6 ? 3'b000 : i == 6 ? 3'b110 : 3'b100);
    end
    hold(1'b1, 10, "release_after_reset");
    for (int r = 0; r < 200; r++) begin
      logic k;
      int len;
      k = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) begin
        step(k);
        chk("random_model", outs(), {acc, e_press, e_rel});
        chk("pulses_exclusive", key_press & key_release, 1'b0);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 9; p++) begin
      hold(1'b0, 10, "counter_press");
      hold(1'b1, 10, "counter_release");
    end
    chk("counter_value", cnt, 3'd1);
    chk("counter_wraps", wraps, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
